// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential 32-bit multiply/divide unit (MULTU/MULT/DIVU/DIV), 33-edge latency.
// Ports: clk, rst (sync active-high), start, op[1:0] (00 MULTU, 01 MULT, 10 DIVU, 11 DIV),
//        rs_val/rt_val (operands), busy, stall, done, div_by_zero, hi/lo (result).
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t      state, state_n;
    logic [4:0]  cnt;
    logic [1:0]  op_r;
    logic [31:0] b_r;
    logic        sgn_r, rsg_r;
    logic [63:0] acc;
    logic        a_neg, b_neg, dz;
    logic [31:0] a_mag, b_mag, quo, rem;
    logic [32:0] mul_sum, rem_sh, rem_diff;
    logic [63:0] step, prod;
    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        a_neg    = op[0] & rs_val[31];
        b_neg    = op[0] & rt_val[31];
        a_mag    = a_neg ? -rs_val : rs_val;
        b_mag    = b_neg ? -rt_val : rt_val;
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_r} : 33'd0);
        rem_sh   = {acc[63:32], acc[31]};
        rem_diff = rem_sh - {1'b0, b_r};
        step     = op_r[1] ? (rem_diff[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                                           : {rem_diff[31:0], acc[30:0], 1'b1})
                           : {mul_sum, acc[31:1]};
        prod     = sgn_r ? -acc : acc;
        quo      = sgn_r ? -acc[31:0] : acc[31:0];
        rem      = rsg_r ? -acc[63:32] : acc[63:32];
        dz       = op_r[1] & (b_r == 32'd0);
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = (state == IDLE) ? (start ? RUN : IDLE) :
                  (state == RUN)  ? ((cnt == 5'd0) ? FIX : RUN) :
                  (state == FIX)  ? DONE : IDLE;
        busy    = state != IDLE;
        done    = state == DONE;
        stall   = ~rst & (((state == IDLE) & start) | (state == RUN) | (state == FIX));
    end
    // divide by zero yields quotient all-ones and remainder |rs| with the dividend's sign,
    // which is rs itself; only lo needs forcing so the sign fix-up cannot disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= 5'd0;
            op_r        <= 2'd0;
            b_r         <= 32'd0;
            sgn_r       <= 1'b0;
            rsg_r       <= 1'b0;
            acc         <= 64'd0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            div_by_zero <= 1'b0;
            if (state == IDLE && start) begin
                op_r  <= op;
                b_r   <= b_mag;
                sgn_r <= a_neg ^ b_neg;
                rsg_r <= a_neg;
                acc   <= {32'd0, a_mag};
                cnt   <= 5'd31;
            end
            if (state == RUN) begin
                acc <= step;
                cnt <= (cnt == 5'd0) ? 5'd0 : cnt - 5'd1;
            end
            if (state == FIX) begin
                hi          <= op_r[1] ? rem : prod[63:32];
                lo          <= op_r[1] ? (dz ? 32'hFFFF_FFFF : quo) : prod[31:0];
                div_by_zero <= dz;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
    logic        busy, stall, done, div_by_zero;
    logic [31:0] hi, lo;
    int n_cmp = 0, n_bad = 0;

    muldiv_seq dut (.clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
                    .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo));

    always #5 clk = ~clk;

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; rs_val = 32'hA5A5_A5A5; rt_val = 32'h5A5A_5A5A;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!done && n < 40);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; rs_val = 32'd3; rt_val = 32'd4;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall_comb: got %b want 0", stall); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0 || div_by_zero !== 1'b0) begin n_bad++; $display("FAIL rst_flags: got done=%b dz=%b want 0 0", done, div_by_zero); end
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_bad++; $display("FAIL rst_hilo: got %h %h want 0 0", hi, lo); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_multu_latency;
        int early_done, low_stall;
        early_done = 0; low_stall = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL multu_stall_e0: got %b want 1", stall); end
        @(posedge clk); #1;
        start = 1'b0; rs_val = 32'd0; rt_val = 32'd0;
        n_cmp++; if (stall !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL multu_run: got stall=%b busy=%b want 1 1", stall, busy); end
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk); #1;
            if (k <= 32 && stall !== 1'b1) low_stall++;
            if (k < 33 && done !== 1'b0) early_done++;
        end
        n_cmp++; if (low_stall != 0 || early_done != 0) begin n_bad++; $display("FAIL multu_timing: got low_stall=%0d early_done=%0d want 0 0", low_stall, early_done); end
        n_cmp++; if (done !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL multu_done_e33: got done=%b stall=%b want 1 0", done, stall); end
        n_cmp++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_result: got %h_%h want fffffffe_00000001", hi, lo); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL multu_e34: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_mult;
        int n;
        launch(2'b01, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_done(n);
        n_cmp++; if (n != 33) begin n_bad++; $display("FAIL mult_neg_latency: got %0d want 33", n); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_neg: got %h_%h want ffffffff_ffffffeb", hi, lo); end
        @(posedge clk); #1;
        launch(2'b01, 32'h8000_0000, 32'h8000_0000);
        wait_done(n);
        n_cmp++; if (hi !== 32'h4000_0000 || lo !== 32'h0000_0000) begin n_bad++; $display("FAIL mult_min: got %h_%h want 40000000_00000000", hi, lo); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int n;
        launch(2'b10, 32'd100, 32'd7);
        wait_done(n);
        n_cmp++; if (lo !== 32'h0000_000E || hi !== 32'h0000_0002) begin n_bad++; $display("FAIL divu_100_7: got hi=%h lo=%h want 00000002 0000000e", hi, lo); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL divu_flag: got %b want 0", div_by_zero); end
        @(posedge clk); #1;
        launch(2'b11, 32'hFFFF_FFF9, 32'd2);
        n_cmp++; if (busy !== 1'b1 || hi !== 32'h0000_0002 || lo !== 32'h0000_000E) begin n_bad++; $display("FAIL b2b_hold: got busy=%b hi=%h lo=%h want 1 00000002 0000000e", busy, hi, lo); end
        wait_done(n);
        n_cmp++; if (n != 33) begin n_bad++; $display("FAIL b2b_latency: got %0d want 33", n); end
        n_cmp++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_m7_2: got hi=%h lo=%h want ffffffff fffffffd", hi, lo); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_overflow;
        int n;
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        n_cmp++; if (lo !== 32'h8000_0000 || hi !== 32'h0000_0000 || div_by_zero !== 1'b0) begin n_bad++; $display("FAIL div_min_m1: got hi=%h lo=%h dz=%b want 00000000 80000000 0", hi, lo, div_by_zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_by_zero;
        int n;
        launch(2'b11, 32'h1234_5678, 32'd0);
        n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL dz_run_flag: got %b want 0", div_by_zero); end
        wait_done(n);
        n_cmp++; if (n != 33) begin n_bad++; $display("FAIL dz_latency: got %0d want 33", n); end
        n_cmp++; if (div_by_zero !== 1'b1 || hi !== 32'h1234_5678 || lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dz_result: got dz=%b hi=%h lo=%h want 1 12345678 ffffffff", div_by_zero, hi, lo); end
        @(posedge clk); #1;
        n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL dz_clear: got %b want 0", div_by_zero); end
    endtask

    task automatic test_ignore_start;
        int n;
        launch(2'b00, 32'd5, 32'd6);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 2'b10; rs_val = 32'd100; rt_val = 32'd100;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        n_cmp++; if (n != 23) begin n_bad++; $display("FAIL ign_latency: got %0d want 23", n); end
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd30) begin n_bad++; $display("FAIL ign_result: got hi=%h lo=%h want 00000000 0000001e", hi, lo); end
        start = 1'b1; op = 2'b00; rs_val = 32'd7; rt_val = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0 || lo !== 32'd30) begin n_bad++; $display("FAIL ign_done_start: got busy=%b lo=%h want 0 0000001e", busy, lo); end
    endtask

    task automatic test_abort;
        int n, pulses;
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin n_bad++; $display("FAIL abort_state: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL abort_stall: got %b want 0", stall); end
        rst = 1'b0; start = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL abort_leak: got %0d bad cycles want 0", pulses); end
        launch(2'b10, 32'd9, 32'd3);
        wait_done(n);
        n_cmp++; if (n != 33) begin n_bad++; $display("FAIL abort_restart_latency: got %0d want 33", n); end
        n_cmp++; if (lo !== 32'd3 || hi !== 32'd0) begin n_bad++; $display("FAIL abort_restart: got hi=%h lo=%h want 00000000 00000003", hi, lo); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_multu_latency;
        test_mult;
        test_back_to_back;
        test_div_overflow;
        test_div_by_zero;
        test_ignore_start;
        test_abort;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 The block SHALL have port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port `start`, input, 1 bit: request a new operation.
REQ-005 The block SHALL have port `op`, input, 2 bits: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 The block SHALL have port `rs_val`, input, 32 bits: multiplicand or dividend.
REQ-007 The block SHALL have port `rt_val`, input, 32 bits: multiplier or divisor.
REQ-008 The block SHALL have port `busy`, output, 1 bit: high whenever state != IDLE.
REQ-009 The block SHALL have port `stall`, output, 1 bit: pipeline hold request; combinational (IDLE & start) | RUN | FIX.
REQ-010 The block SHALL have port `done`, output, 1 bit: one-cycle result-valid pulse; high only in state DONE.
REQ-011 The block SHALL have port `div_by_zero`, output, 1 bit: high with `done` when a DIV/DIVU had rt_val == 0.
REQ-012 The block SHALL have port `hi`, output, 32 bits: product[63:32] or remainder.
REQ-013 The block SHALL have port `lo`, output, 32 bits: product[31:0] or quotient.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, FIX, DONE.
REQ-015 In IDLE with start=1 at edge E0, the block SHALL latch op, rs_val and rt_val and enter RUN; later changes to these inputs SHALL have no effect on the result.
REQ-016 For signed ops, the block SHALL latch operand magnitudes and record the result sign, plus the remainder sign (sign of the dividend).
REQ-017 RUN SHALL last exactly 32 cycles (edges E1..E32), driven by a 5-bit iteration counter loaded with 31 at E0 and decremented each RUN cycle; RUN exits to FIX when the counter is 0.
REQ-018 Each multiply step SHALL be a shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
REQ-019 Each divide step SHALL be a restoring step: shift the remainder left by one, subtract the divisor, restore if negative, shift the quotient bit in.
REQ-020 FIX (edge E33) SHALL apply two's-complement negation to the product, quotient and remainder as the recorded signs require, then go to DONE.
REQ-021 hi and lo SHALL be written only on the FIX->DONE edge and SHALL hold otherwise.
REQ-022 DONE SHALL last one cycle, then return to IDLE at E34.
REQ-023 Start-to-done latency SHALL be 33 edges: done is high between E33 and E34.
REQ-024 A new start SHALL be accepted in IDLE at E34 or later; back-to-back operations are allowed.
REQ-025 start while busy=1 (including in DONE) SHALL be ignored: no relatch and no restart.
REQ-026 Signed division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-027 DIV with 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no flag.
REQ-028 Divide by zero SHALL still take the full latency and SHALL give hi=rs_val (latched), lo=0xFFFFFFFF, and div_by_zero=1 during DONE.
REQ-029 div_by_zero SHALL be 0 in every state except DONE.
REQ-030 Multiply results SHALL be the full 64-bit product (no truncation); MULT uses signed operands, MULTU unsigned.

Reset
REQ-031 While rst=1 at an edge, the block SHALL go to IDLE with hi=0, lo=0, done=0, div_by_zero=0, busy=0, counter=0 and all operand registers cleared.
REQ-032 rst SHALL take priority over start in the same cycle.
REQ-033 rst asserted mid-RUN or in FIX SHALL abort the operation, and the aborted result SHALL never appear on hi/lo.
REQ-034 After rst deasserts, the first start SHALL behave exactly as a start from power-up.
REQ-035 stall SHALL be 0 while rst=1.

Verification
REQ-036 MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at E0 -> done only between E33 and E34; hi=0xFFFFFFFE, lo=0x00000001; stall high from E0 through E32.
REQ-037 MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-038 DIVU 100 / 7 -> lo=0x0000000E, hi=0x00000002. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 DIV 0x12345678 / 0 -> after 33 edges, done=1, div_by_zero=1, hi=0x12345678, lo=0xFFFFFFFF; div_by_zero=0 the next cycle.
REQ-040 start a MULTU 5 x 6, then re-pulse start with new operands at E10, which is ignored -> result hi=0, lo=30 at E33.
REQ-041 Start a new op; assert rst at E10 -> busy=0, hi=lo=0, done never pulses; then DIVU 9 / 3 -> lo=3, hi=0, with correct latency.
